// File: rtl/kmeans_cluster_accum_if.sv
// Batch-input and shared float-adder handshake bundle for kmeans_cluster_accum.
// master = environment (point source plus adder), slave = the accumulator.
interface kmeans_cluster_accum_if #(
   parameter int K     = 3,
   parameter int LANES = 4,
   parameter int DW    = 32,
   parameter int IW    = (K > 2) ? $clog2(K) : 1
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*DW-1:0]   in_x;
   logic [LANES*DW-1:0]   in_y;
   logic [LANES*IW-1:0]   in_k;
   logic [LANES-1:0]      in_mask;

   logic                  fa_req;
   logic [DW-1:0]         fa_a_x;
   logic [DW-1:0]         fa_b_x;
   logic [DW-1:0]         fa_a_y;
   logic [DW-1:0]         fa_b_y;
   logic                  fa_ack;
   logic [DW-1:0]         fa_z_x;
   logic [DW-1:0]         fa_z_y;

   modport master (
      output in_valid, in_x, in_y, in_k, in_mask, fa_ack, fa_z_x, fa_z_y,
      input  in_ready, fa_req, fa_a_x, fa_b_x, fa_a_y, fa_b_y
   );

   modport slave (
      input  in_valid, in_x, in_y, in_k, in_mask, fa_ack, fa_z_x, fa_z_y,
      output in_ready, fa_req, fa_a_x, fa_b_x, fa_a_y, fa_b_y
   );
endinterface

// File: rtl/kmeans_cluster_accum.sv
// Per-cluster float x/y accumulator: serialises each valid lane of a batch through
// one shared external dual float adder and keeps saturating per-cluster point counts.
module kmeans_cluster_accum #(
   parameter int K     = 3,
   parameter int LANES = 4,
   parameter int DW    = 32,
   parameter int CW    = 32,
   parameter int IW    = (K > 2) ? $clog2(K) : 1
) (
   input  logic                  clk,
   input  logic                  rstnn,
   input  logic                  clear_i,
   kmeans_cluster_accum_if.slave acc_if,
   output logic [K*DW-1:0]       sum_x_o,
   output logic [K*DW-1:0]       sum_y_o,
   output logic [K*CW-1:0]       count_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);
   localparam int            LW      = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IW:0]   K_LIM   = (IW+1)'(K);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_REQ  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LANES*DW-1:0] bx_q, by_q;
   logic [LANES*IW-1:0] bk_q;
   logic [LANES-1:0]    mask_q, mask_d;
   logic [LW-1:0]       lane_q, lane_d;
   logic [IW-1:0]       selk_q, selk_d;
   logic                err_q, err_d;
   logic                fa_req_q, fa_req_d;
   logic [DW-1:0]       a_x_q, a_x_d, b_x_q, b_x_d;
   logic [DW-1:0]       a_y_q, a_y_d, b_y_q, b_y_d;
   logic                done_q, busy_q, in_ready_q;
   logic [DW-1:0]       sum_x_q [K];
   logic [DW-1:0]       sum_y_q [K];
   logic [CW-1:0]       cnt_q   [K];

   logic [LANES-1:0]    oor_s, live_s;
   logic [LW-1:0]       pick_s;
   logic [IW-1:0]       pick_k_s;
   logic [DW-1:0]       pick_x_s, pick_y_s, cur_x_s, cur_y_s;
   logic                accept_s, ack_s;

   // Flag masked-in lanes whose cluster index is out of range; the rest are live.
   always_comb begin
      oor_s = '0;
      for (int i = 0; i < LANES; i++) begin
         oor_s[i] = mask_q[i] & ({1'b0, bk_q[i*IW +: IW]} >= K_LIM);
      end
      live_s = mask_q & ~oor_s;
   end

   // Lowest-numbered live lane wins; descending scan lets lane 0 overwrite last.
   always_comb begin
      pick_s   = '0;
      pick_k_s = '0;
      pick_x_s = '0;
      pick_y_s = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         pick_s   = live_s[i] ? LW'(i)            : pick_s;
         pick_k_s = live_s[i] ? bk_q[i*IW +: IW]  : pick_k_s;
         pick_x_s = live_s[i] ? bx_q[i*DW +: DW]  : pick_x_s;
         pick_y_s = live_s[i] ? by_q[i*DW +: DW]  : pick_y_s;
      end
   end

   // Running sums of the selected cluster, read one cycle after any prior write-back.
   always_comb begin
      cur_x_s = '0;
      cur_y_s = '0;
      for (int c = 0; c < K; c++) begin
         cur_x_s = (pick_k_s == IW'(c)) ? sum_x_q[c] : cur_x_s;
         cur_y_s = (pick_k_s == IW'(c)) ? sum_y_q[c] : cur_y_s;
      end
   end

   assign ack_s = (state_q == S_REQ) && acc_if.fa_ack && !clear_i;

   // Next-state and datapath-control logic; clear overrides everything.
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      lane_d   = lane_q;
      selk_d   = selk_q;
      err_d    = err_q;
      fa_req_d = fa_req_q;
      a_x_d    = a_x_q;
      b_x_d    = b_x_q;
      a_y_d    = a_y_q;
      b_y_d    = b_y_q;
      accept_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (acc_if.in_valid && in_ready_q) begin
               accept_s = 1'b1;
               mask_d   = acc_if.in_mask;
               state_d  = S_SCAN;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_SCAN: begin
            err_d  = err_q | (|oor_s);
            mask_d = live_s;
            if (|live_s) begin
               lane_d   = pick_s;
               selk_d   = pick_k_s;
               a_x_d    = cur_x_s;
               a_y_d    = cur_y_s;
               b_x_d    = pick_x_s;
               b_y_d    = pick_y_s;
               fa_req_d = 1'b1;
               state_d  = S_REQ;
            end else begin
               state_d  = S_DONE;
            end
         end
         S_REQ: begin
            if (acc_if.fa_ack) begin
               mask_d[lane_q] = 1'b0;
               fa_req_d       = 1'b0;
               state_d        = S_SCAN;
            end else begin
               state_d        = S_REQ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (clear_i) begin
         state_d  = S_IDLE;
         mask_d   = '0;
         err_d    = 1'b0;
         fa_req_d = 1'b0;
         a_x_d    = '0;
         b_x_d    = '0;
         a_y_d    = '0;
         b_y_d    = '0;
         accept_s = 1'b0;
      end else begin
         accept_s = accept_s;
      end
   end

   // Control state, handshake outputs and status flags.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_q    <= S_IDLE;
         mask_q     <= '0;
         lane_q     <= '0;
         selk_q     <= '0;
         err_q      <= 1'b0;
         fa_req_q   <= 1'b0;
         a_x_q      <= '0;
         b_x_q      <= '0;
         a_y_q      <= '0;
         b_y_q      <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         lane_q     <= lane_d;
         selk_q     <= selk_d;
         err_q      <= err_d;
         fa_req_q   <= fa_req_d;
         a_x_q      <= a_x_d;
         b_x_q      <= b_x_d;
         a_y_q      <= a_y_d;
         b_y_q      <= b_y_d;
         done_q     <= (state_q == S_DONE) && !clear_i;
         busy_q     <= (state_d != S_IDLE);
         // Held low through the first IDLE cycle so batches are spaced apart.
         in_ready_q <= (state_d == S_IDLE) && (state_q == S_IDLE);
      end
   end

   // Batch capture on accept.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         bx_q <= '0;
         by_q <= '0;
         bk_q <= '0;
      end else if (accept_s) begin
         bx_q <= acc_if.in_x;
         by_q <= acc_if.in_y;
         bk_q <= acc_if.in_k;
      end else begin
         bx_q <= bx_q;
         by_q <= by_q;
         bk_q <= bk_q;
      end
   end

   // Per-cluster sums and saturating counts, written back on adder ack.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         for (int c = 0; c < K; c++) begin
            sum_x_q[c] <= '0;
            sum_y_q[c] <= '0;
            cnt_q[c]   <= '0;
         end
      end else if (clear_i) begin
         for (int c = 0; c < K; c++) begin
            sum_x_q[c] <= '0;
            sum_y_q[c] <= '0;
            cnt_q[c]   <= '0;
         end
      end else if (ack_s) begin
         for (int c = 0; c < K; c++) begin
            if (selk_q == IW'(c)) begin
               sum_x_q[c] <= acc_if.fa_z_x;
               sum_y_q[c] <= acc_if.fa_z_y;
               cnt_q[c]   <= (cnt_q[c] == CNT_MAX) ? cnt_q[c] : cnt_q[c] + CW'(1);
            end else begin
               cnt_q[c]   <= cnt_q[c];
            end
         end
      end else begin
         for (int c = 0; c < K; c++) begin
            cnt_q[c] <= cnt_q[c];
         end
      end
   end

   for (genvar c = 0; c < K; c++) begin : g_flat
      assign sum_x_o[c*DW +: DW] = sum_x_q[c];
      assign sum_y_o[c*DW +: DW] = sum_y_q[c];
      assign count_o[c*CW +: CW] = cnt_q[c];
   end

   assign acc_if.in_ready = in_ready_q;
   assign acc_if.fa_req   = fa_req_q;
   assign acc_if.fa_a_x   = a_x_q;
   assign acc_if.fa_b_x   = b_x_q;
   assign acc_if.fa_a_y   = a_y_q;
   assign acc_if.fa_b_y   = b_y_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign err_o           = err_q;
endmodule

// File: doc/kmeans_cluster_accum.md
# kmeans_cluster_accum

Parameterised per-cluster accumulator for the k-means float datapath. It takes batches of LANES points, each with a cluster index and a lane-valid mask, and adds each valid point's x/y into that cluster's running IEEE-754 single-precision sums. It also increments the cluster's point count. Additions are serialised through one shared external dual (x/y) float adder via a req/ack handshake. The block sits between the distance/argmin stage and the centroid-update (divide) stage.

## Interface
- K, 3, number of clusters (2..16)
- LANES, 4, points per batch (1..8)
- DW, 32, float word width
- CW, 32, count width
- IW, derived: $clog2(K) (minimum 1), cluster index width
- clk  in  1  clock
- rstnn  in  1  reset; asynchronous, active-low
- clear  in  1  synchronous clear of sums, counts and err; aborts any batch in progress
- in_valid  in  1  batch valid
- in_ready  out  1  high only in IDLE
- in_x, in_y  in  LANES*DW each  lane i at bits [i*DW +: DW]
- in_k  in  LANES*IW  cluster index per lane
- in_mask  in  LANES  lane valid (replaces the old index-5 sentinel)
- fa_req  out  1  adder request, held until ack
- fa_a_x, fa_b_x, fa_a_y, fa_b_y  out  DW each  adder operands (a = running sum, b = point)
- fa_ack  in  1  adder result valid, single-cycle pulse
- fa_z_x, fa_z_y  in  DW each  adder results, sampled when fa_ack=1
- sum_x, sum_y  out  K*DW each  cluster c at [c*DW +: DW]
- count  out  K*CW  per-cluster point counts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of batch
- err  out  1  sticky: a masked-in lane carried in_k >= K

## Operation
- States: IDLE, SCAN, REQ, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: latch in_x, in_y, in_k and in_mask into the batch registers, then go to SCAN.
- SCAN (1 cycle)
  - If any remaining mask bit has k >= K: clear all such bits and set err. Same cycle, continue.
  - If no bits remain: go to DONE.
  - Otherwise select the lowest-numbered remaining lane L and go to REQ.
- REQ
  - fa_req=1.
  - fa_a_x/fa_a_y = sum_x[k_L]/sum_y[k_L]; fa_b_x/fa_b_y = lane L point. Operands are stable while fa_req is high.
  - On fa_ack:
    - sum_x[k_L] <= fa_z_x and sum_y[k_L] <= fa_z_y.
    - count[k_L] <= count+1, saturating at 2^CW-1.
    - Clear mask bit L; fa_req drops next cycle; go to SCAN.
- DONE
  - done=1 for 1 cycle, then return to IDLE.
- Several lanes with the same cluster are safe: each write-back completes before the next operand read.
- Sums are never reset between batches. Only rstnn and clear zero them.
- clear in any state:
  - Zero all sums, counts and err; fa_req=0; go to IDLE; no done pulse.
  - An fa_ack arriving after the abort is ignored.
  - clear together with in_valid in IDLE: clear wins and the batch is not accepted.
- fa_ack outside REQ is ignored.

## Timing
- Reset values:
  - sum_x, sum_y, count all 0; err=0.
  - fa_req=0; fa_a_x, fa_b_x, fa_a_y, fa_b_y = 0.
  - done=0; busy=0; in_ready=1; state IDLE.
- Batch latency from the accept edge to the done pulse: (number of valid in-range lanes) × (2 + adder latency) + 2 cycles.
- Adder latency counts fa_req rising to fa_ack, minimum 1 cycle.
- Empty mask: SCAN, then DONE; done pulses 2 cycles after accept.
- in_ready returns the cycle after done. Back-to-back batches are spaced by at least 1 IDLE cycle.
- Outputs are registers; sums and counts are updated the cycle after fa_ack.

## Test plan
- Reset, then one batch with K=3, mask=4'b1111, in_k={0,1,2,0}, x={1.0,2.0,3.0,1.0} (0x3F800000, 0x40000000, 0x40400000, 0x3F800000), y = x, adder latency 3:
  - sum_x[0]=0x40000000, sum_x[1]=0x40000000, sum_x[2]=0x40400000.
  - counts {2,1,1}; done after 4×5+2=22 cycles.
- mask=4'b0101 (replacing the old sentinel), all lanes k=1, x=1.0:
  - sum_x[1]=0x40000000, count[1]=2; lanes 1 and 3 untouched; exactly 2 fa_req transactions.
- Lane with mask=1 and in_k=3 (K=3), other lanes valid:
  - err=1 and stays 1; that lane is skipped; other clusters accumulate normally; clear drops err to 0.
- Two batches back-to-back, with random adder latency 1..6:
  - Sums equal a reference float model of all 8 points; in_ready stays low from accept until the cycle after done.
- clear asserted mid-REQ with fa_ack arriving 2 cycles later:
  - All sums and counts 0; state IDLE; late ack ignored; no done pulse.
- CW=4 with 20 points into cluster 0:
  - count[0] saturates at 15; sums keep accumulating.
